// File: rtl/updown_count_ctrl_pkg.sv
// updown_count_ctrl_pkg: channel FSM encodings and timer sizing helper for updown_count_ctrl
package updown_count_ctrl_pkg;
  typedef logic [1:0] btn_state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRESS  = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_REPEAT = 2'd3;
  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/updown_count_ctrl_btn_conditioner.sv
// updown_count_ctrl_btn_conditioner: sync, debounce and press/auto-repeat sequencing for one button
//  clk          in   system clock
//  rst_n        in   asynchronous active-low reset
//  i_btn        in   raw asynchronous button level, active-high
//  o_step_req   out  registered 1-cycle step request
module updown_count_ctrl_btn_conditioner
  import updown_count_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_step_req
);
  localparam int DW   = cnt_w(DEBOUNCE_CYCLES);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = cnt_w(TMAX);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  logic [1:0]    r_sync;
  logic          r_deb;
  logic [DW-1:0] r_deb_cnt;
  btn_state_t    r_state, w_state_nx;
  logic [TW-1:0] r_tmr, w_tmr_nx;
  logic          r_step_req, w_step_nx;
  logic          w_differ, w_deb_flip;
  assign w_differ   = r_sync[1] != r_deb;
  assign w_deb_flip = w_differ && r_deb_cnt == DEB_LAST;
  // Any agreeing cycle restarts the stability count, so only an unbroken run flips the level.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync    <= '0;
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_deb_cnt <= (!w_differ || w_deb_flip) ? '0 : r_deb_cnt + 1'b1;
      r_deb     <= w_deb_flip ? r_sync[1] : r_deb;
    end
  // A debounced low returns to IDLE from anywhere; the IDLE->PRESS transition itself issues the
  // press step so the request is registered one edge after the level is accepted.
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = '0;
    w_step_nx  = 1'b0;
    if (!r_deb) w_state_nx = ST_IDLE;
    else
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_PRESS;
          w_step_nx  = 1'b1;
        end
        ST_PRESS: w_state_nx = ST_HOLD;
        ST_HOLD:
          if (REPEAT_DELAY != 0) begin
            w_state_nx = (r_tmr == DLY_LAST) ? ST_REPEAT : ST_HOLD;
            w_tmr_nx   = (r_tmr == DLY_LAST) ? '0 : r_tmr + 1'b1;
          end
        default: begin
          w_step_nx = r_tmr == PER_LAST;
          w_tmr_nx  = w_step_nx ? '0 : r_tmr + 1'b1;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_step_req <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tmr      <= w_tmr_nx;
      r_step_req <= w_step_nx;
    end
  assign o_step_req = r_step_req;
endmodule

// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: debounced up/down button arbiter owning a saturating or wrapping counter
//  clk          in   system clock
//  rst_n        in   asynchronous active-low reset
//  i_inc_btn    in   raw increment button, async, active-high
//  i_dec_btn    in   raw decrement button, async, active-high
//  i_clr        in   synchronous clear, count is 0 after the next edge
//  o_count      out  current count
//  o_at_max     out  count == MAX_COUNT
//  o_at_min     out  count == 0
//  o_step_inc   out  increment step issued this cycle
//  o_step_dec   out  decrement step issued this cycle
//  o_wrapped    out  count wrapped this cycle (WRAP=1 only)
module updown_count_ctrl
  import updown_count_ctrl_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int MAX_COUNT       = 1023,
  parameter int WRAP            = 0,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc_btn,
  input  logic             i_dec_btn,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_max,
  output logic             o_at_min,
  output logic             o_step_inc,
  output logic             o_step_dec,
  output logic             o_wrapped
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic             WRAP_EN = WRAP != 0;
  if (MAX_COUNT < 1 || longint'(MAX_COUNT) >= (longint'(1) << WIDTH)) begin : g_max_check
    $error("MAX_COUNT must lie in 1..2**WIDTH-1");
  end
  logic             w_inc_req, w_dec_req;
  logic [WIDTH-1:0] r_count, w_count_nx;
  updown_count_ctrl_btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_inc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (i_inc_btn),
    .o_step_req(w_inc_req)
  );
  updown_count_ctrl_btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (i_dec_btn),
    .o_step_req(w_dec_req)
  );
  // Coincident requests cancel each other; clear wins over any step in its cycle.
  assign o_step_inc = w_inc_req & ~w_dec_req & ~i_clr;
  assign o_step_dec = w_dec_req & ~w_inc_req & ~i_clr;
  assign o_at_max   = r_count == MAX_V;
  assign o_at_min   = r_count == '0;
  assign o_wrapped  = WRAP_EN & ((o_step_inc & o_at_max) | (o_step_dec & o_at_min));
  always_comb
    w_count_nx = i_clr      ? '0 :
                 o_step_inc ? (o_at_max ? (WRAP_EN ? '0 : r_count) : r_count + 1'b1) :
                 o_step_dec ? (o_at_min ? (WRAP_EN ? MAX_V : r_count) : r_count - 1'b1) :
                 r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else r_count <= w_count_nx;
  assign o_count = r_count;
endmodule

// File: tb/tb_updown_count_ctrl.sv
// tb_updown_count_ctrl: directed scoreboard bench for saturating and wrapping updown_count_ctrl
module tb_updown_count_ctrl;
  localparam int MAXC = 9;
  logic clk = 1'b0, rst_n = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0, clr = 1'b0;
  logic [3:0] cnt0, cnt1;
  logic mx0, mn0, si0, sd0, wr0, mx1, mn1, si1, sd1, wr1;
  int cyc = 0, n_tests = 0, n_fail = 0, m0 = 0, m1 = 0;
  typedef struct {
    int   cyc;
    logic inc;
    logic dec;
    logic w1;
    int   c0;
    int   c1;
  } ev_t;
  ev_t sb[$];
  ev_t mon_e;
  logic pend = 1'b0;
  int pc0, pc1;

  updown_count_ctrl #(.WIDTH(4), .MAX_COUNT(MAXC), .WRAP(0), .DEBOUNCE_CYCLES(4),
                      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_inc_btn(inc_btn), .i_dec_btn(dec_btn), .i_clr(clr),
    .o_count(cnt0), .o_at_max(mx0), .o_at_min(mn0), .o_step_inc(si0), .o_step_dec(sd0),
    .o_wrapped(wr0));
  updown_count_ctrl #(.WIDTH(4), .MAX_COUNT(MAXC), .WRAP(1), .DEBOUNCE_CYCLES(4),
                      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .i_inc_btn(inc_btn), .i_dec_btn(dec_btn), .i_clr(clr),
    .o_count(cnt1), .o_at_max(mx1), .o_at_min(mn1), .o_step_inc(si1), .o_step_dec(sd1),
    .o_wrapped(wr1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic void push_step(input logic inc, input logic dec, input int e);
    ev_t r;
    r.cyc = e;
    r.inc = inc & ~dec;
    r.dec = dec & ~inc;
    r.w1  = 1'b0;
    if (r.inc) begin
      r.w1 = (m1 == MAXC);
      m0 = (m0 == MAXC) ? m0 : m0 + 1;
      m1 = (m1 == MAXC) ? 0 : m1 + 1;
    end
    if (r.dec) begin
      r.w1 = (m1 == 0);
      m0 = (m0 == 0) ? 0 : m0 - 1;
      m1 = (m1 == 0) ? MAXC : m1 - 1;
    end
    r.c0 = m0;
    r.c1 = m1;
    sb.push_back(r);
  endfunction

  // Input high from edge c0+1: press step at c0+7, HOLD for 10 cycles, then a repeat step every
  // 3 cycles from c0+21 for as long as the debounced level (falls 6 edges after release) is high.
  function automatic void plan(input logic inc, input logic dec, input int c0, input int last);
    for (int e = c0 + 7; e <= last; e = (e == c0 + 7) ? c0 + 21 : e + 3) push_step(inc, dec, e);
  endfunction

  task automatic hold(input logic inc, input logic dec, input int h);
    plan(inc, dec, cyc, cyc + h + 6);
    inc_btn = inc;
    dec_btn = dec;
    cycles(h);
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    cycles(12);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    m0 = 0;
    m1 = 0;
    chk("clr_count_sat", 32'(cnt0), 0);
    chk("clr_count_wrap", 32'(cnt1), 0);
  endtask

  always @(negedge clk) begin
    if (pend) begin
      chk("count_after_step_sat", 32'(cnt0), pc0);
      chk("count_after_step_wrap", 32'(cnt1), pc1);
      pend = 1'b0;
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk("step_inc_sat", 32'(si0), 32'(mon_e.inc));
      chk("step_dec_sat", 32'(sd0), 32'(mon_e.dec));
      chk("wrapped_sat", 32'(wr0), 0);
      chk("step_inc_wrap", 32'(si1), 32'(mon_e.inc));
      chk("step_dec_wrap", 32'(sd1), 32'(mon_e.dec));
      chk("wrapped_wrap", 32'(wr1), 32'(mon_e.w1));
      pend = 1'b1;
      pc0 = mon_e.c0;
      pc1 = mon_e.c1;
    end else if (rst_n) chk("no_pulse", 32'({si0, sd0, wr0, si1, sd1, wr1}), 0);
  end

  initial begin
    cycles(2);
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_at_min", 32'(mn0), 1);
    chk("rst_at_max", 32'(mx0), 0);
    chk("rst_pulses", 32'({si0, sd0, wr0, si1, sd1, wr1}), 0);
    rst_n = 1'b1;
    cycles(2);
    // clean press: step pulse 7 edges after the input rises, count one edge later
    hold(1'b1, 1'b0, 6);
    chk("t1_count", 32'(cnt0), 1);
    // bounce never stays stable for 4 cycles
    do_clr();
    for (int i = 0; i < 6; i++) begin
      inc_btn = (i % 2 == 0) || (i == 5);
      cycles(1);
    end
    inc_btn = 1'b0;
    cycles(12);
    chk("t2_count", 32'(cnt0), 0);
    // 30-cycle hold: press step then repeats at +21,+24,+27,+30,+33,+36
    hold(1'b1, 1'b0, 30);
    chk("t3_count", 32'(cnt0), 7);
    chk("t3_at_max", 32'(mx0), 0);
    // upper limit
    hold(1'b1, 1'b0, 6);
    hold(1'b1, 1'b0, 6);
    chk("t4_preload", 32'(cnt0), 9);
    chk("t4_preload_at_max", 32'(mx0), 1);
    hold(1'b1, 1'b0, 6);
    chk("t4_sat_count", 32'(cnt0), 9);
    chk("t4_sat_at_max", 32'(mx0), 1);
    chk("t4_wrap_count", 32'(cnt1), 0);
    chk("t4_wrap_at_min", 32'(mn1), 1);
    // lower limit
    do_clr();
    hold(1'b0, 1'b1, 6);
    chk("t4_dec_sat_count", 32'(cnt0), 0);
    chk("t4_dec_wrap_count", 32'(cnt1), 9);
    chk("t4_dec_wrap_at_max", 32'(mx1), 1);
    // coincident requests at 5
    do_clr();
    for (int i = 0; i < 5; i++) hold(1'b1, 1'b0, 6);
    chk("t5_preload", 32'(cnt0), 5);
    hold(1'b1, 1'b1, 6);
    chk("t5_both_count", 32'(cnt0), 5);
    hold(1'b0, 1'b1, 6);
    chk("t5_dec_count", 32'(cnt0), 4);
    // reset during auto-repeat at count 7
    do_clr();
    plan(1'b1, 1'b0, cyc, cyc + 36);
    inc_btn = 1'b1;
    cycles(37);
    chk("t6_pre_count", 32'(cnt0), 7);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count_sat", 32'(cnt0), 0);
    chk("t6_rst_count_wrap", 32'(cnt1), 0);
    chk("t6_rst_at_min", 32'(mn0), 1);
    cycles(2);
    rst_n = 1'b1;
    m0 = 0;
    m1 = 0;
    plan(1'b1, 1'b0, cyc, cyc + 17);
    cycles(11);
    inc_btn = 1'b0;
    cycles(12);
    chk("t6_after_count", 32'(cnt0), 1);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
